product_accumulator: RTL



---
 rtl/product_accumulator.sv | 92 +++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// Product accumulator: sums a programmed count of signed products into a
// guard-bit-extended accumulator and returns the sum over a valid/ready port.
module product_accumulator #(
  parameter int PW = 64,
  parameter int GW = 8,
  parameter int CW = 16,
  localparam int AW = PW + GW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] num_terms,
  input  logic          p_valid,
  output logic          p_ready,
  input  logic [PW-1:0] p_data,
  output logic          acc_valid,
  input  logic          acc_ready,
  output logic [AW-1:0] acc_data,
  output logic          busy,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] remaining;

  logic [AW-1:0] addend, sum;
  logic          ovf_step, p_fire;

  assign addend   = {{GW{p_data[PW-1]}}, p_data};
  assign sum      = acc + addend;
  // Signed overflow: like-signed operands producing an opposite-signed result.
  assign ovf_step = (acc[AW-1] == addend[AW-1]) && (sum[AW-1] != acc[AW-1]);
  assign p_fire   = p_valid && p_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      p_ready   <= 1'b0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            acc      <= '0;
            busy     <= 1'b1;
            if (num_terms != '0) begin
              remaining <= num_terms;
              p_ready   <= 1'b1;
              state     <= ACCUM;
            end else begin
              acc_data  <= '0;
              acc_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (p_fire) begin
            acc       <= sum;
            remaining <= remaining - CW'(1);
            if (ovf_step) overflow <= 1'b1;
            // Last term: publish the sum including it directly from the adder.
            if (remaining == CW'(1)) begin
              p_ready   <= 1'b0;
              acc_valid <= 1'b1;
              acc_data  <= sum;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            acc_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
